// File: rtl/alu_seq_muldiv.sv
// Multi-cycle unsigned MUL/DIV sequencer that borrows the execute-stage ALU,
// issuing one ALU operation per cycle and capturing its result at the edge.
module alu_seq_muldiv #(
    parameter int          WIDTH    = 32,
    parameter logic [3:0]  CL_ADD   = 4'b0010,
    parameter logic [3:0]  CL_SUB   = 4'b0011,
    parameter logic [3:0]  CL_SHL   = 4'b0100,
    parameter logic [3:0]  CL_SHR   = 4'b0101,
    parameter logic [3:0]  CL_PASSB = 4'b0111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             dz,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_cline,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_M_ADD,
        S_M_SHL,
        S_M_SHR,
        S_D_SHL,
        S_D_SUB,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // acc doubles as the DIV remainder, mcand as the shifting dividend and
    // mplr as the constant divisor, so both loops share one register set.
    logic             op_reg,     op_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0] mcand_reg,  mcand_next;
    logic [WIDTH-1:0] mplr_reg,   mplr_next;
    logic [WIDTH-1:0] quo_reg,    quo_next;
    logic [4:0]       cnt_reg,    cnt_next;
    logic             carry_reg,  carry_next;
    logic [WIDTH-1:0] res_lo_reg, res_lo_next;
    logic [WIDTH-1:0] res_hi_reg, res_hi_next;
    logic             dz_reg,     dz_next;

    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] quo_new;
    logic             quo_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= 1'b0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplr_reg   <= '0;
            quo_reg    <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            res_lo_reg <= '0;
            res_hi_reg <= '0;
            dz_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplr_reg   <= mplr_next;
            quo_reg    <= quo_next;
            cnt_reg    <= cnt_next;
            carry_reg  <= carry_next;
            res_lo_reg <= res_lo_next;
            res_hi_reg <= res_hi_next;
            dz_reg     <= dz_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplr_next   = mplr_reg;
        quo_next    = quo_reg;
        cnt_next    = cnt_reg;
        carry_next  = carry_reg;
        res_lo_next = res_lo_reg;
        res_hi_next = res_hi_reg;
        dz_next     = dz_reg;
        alu_a       = '0;
        alu_b       = '0;
        alu_cline   = CL_PASSB;
        rem_new     = acc_reg;
        quo_bit     = 1'b0;
        quo_new     = quo_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    op_next     = op;
                    mcand_next  = opa;
                    mplr_next   = opb;
                    acc_next    = '0;
                    quo_next    = '0;
                    cnt_next    = '0;
                    carry_next  = 1'b0;
                    res_lo_next = '0;
                    res_hi_next = '0;
                    dz_next     = 1'b0;
                    state_next  = S_CHK;
                end
            end

            S_CHK: begin
                // Route the divisor/multiplier through the ALU to get its zero flag.
                alu_b     = mplr_reg;
                alu_cline = CL_PASSB;
                if (alu_zero) begin
                    if (op_reg) begin
                        res_lo_next = '1;
                        res_hi_next = mcand_reg;
                        dz_next     = 1'b1;
                    end else begin
                        res_lo_next = '0;
                    end
                    state_next = S_DONE;
                end else begin
                    acc_next   = '0;
                    quo_next   = '0;
                    carry_next = 1'b0;
                    cnt_next   = 5'd31;
                    if (op_reg)
                        state_next = S_D_SHL;
                    else if (mplr_reg[0])
                        state_next = S_M_ADD;
                    else
                        state_next = S_M_SHL;
                end
            end

            S_M_ADD: begin
                alu_a      = acc_reg;
                alu_b      = mcand_reg;
                alu_cline  = CL_ADD;
                acc_next   = alu_res;
                state_next = S_M_SHL;
            end

            S_M_SHL: begin
                alu_a      = mcand_reg;
                alu_b      = WIDTH'(1);
                alu_cline  = CL_SHL;
                mcand_next = alu_res;
                state_next = S_M_SHR;
            end

            S_M_SHR: begin
                alu_a     = mplr_reg;
                alu_b     = WIDTH'(1);
                alu_cline = CL_SHR;
                mplr_next = alu_res;
                // Stop as soon as no multiplier bits remain.
                if (alu_zero) begin
                    res_lo_next = acc_reg;
                    res_hi_next = '0;
                    state_next  = S_DONE;
                end else if (alu_res[0]) begin
                    state_next = S_M_ADD;
                end else begin
                    state_next = S_M_SHL;
                end
            end

            S_D_SHL: begin
                alu_a      = acc_reg;
                alu_b      = WIDTH'(1);
                alu_cline  = CL_SHL;
                carry_next = acc_reg[WIDTH-1];
                acc_next   = alu_res | {{(WIDTH-1){1'b0}}, mcand_reg[WIDTH-1]};
                mcand_next = {mcand_reg[WIDTH-2:0], 1'b0};
                state_next = S_D_SUB;
            end

            S_D_SUB: begin
                alu_a     = acc_reg;
                alu_b     = mplr_reg;
                alu_cline = CL_SUB;
                // The shifted-out carry makes the remainder 33 bits wide here.
                if ({carry_reg, acc_reg} >= {1'b0, mplr_reg}) begin
                    rem_new = alu_res;
                    quo_bit = 1'b1;
                end
                quo_new  = {quo_reg[WIDTH-2:0], quo_bit};
                acc_next = rem_new;
                quo_next = quo_new;
                if (cnt_reg == 5'd0) begin
                    res_lo_next = quo_new;
                    res_hi_next = rem_new;
                    state_next  = S_DONE;
                end else begin
                    cnt_next   = cnt_reg - 5'd1;
                    state_next = S_D_SHL;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done   = (state_reg == S_DONE);
    assign res_lo = res_lo_reg;
    assign res_hi = res_hi_reg;
    assign dz     = dz_reg;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Bench for alu_seq_muldiv: behavioural ALU, directed vector table, corner
// sequences (busy-start, mid-op reset) and randomized ops vs. a plain-math model.
module tb_alu_seq_muldiv;

    localparam logic [3:0] CL_ADD   = 4'b0010;
    localparam logic [3:0] CL_SUB   = 4'b0011;
    localparam logic [3:0] CL_SHL   = 4'b0100;
    localparam logic [3:0] CL_SHR   = 4'b0101;
    localparam logic [3:0] CL_PASSB = 4'b0111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy, done, dz;
    logic [31:0] res_lo, res_hi, alu_a, alu_b, alu_res;
    logic [3:0]  alu_cline;
    logic        alu_zero;

    always #5 clk = ~clk;

    // Execution-unit ALU model.
    always_comb begin
        case (alu_cline)
            CL_ADD:   alu_res = alu_a + alu_b;
            CL_SUB:   alu_res = alu_a - alu_b;
            CL_SHL:   alu_res = alu_a << alu_b;
            CL_SHR:   alu_res = alu_a >> alu_b;
            CL_PASSB: alu_res = alu_b;
            default:  alu_res = '0;
        endcase
    end
    assign alu_zero = (alu_res == 32'd0);

    alu_seq_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .busy      (busy),
        .done      (done),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .dz        (dz),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cline (alu_cline),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
    } vec_t;

    vec_t       vecs [8];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] cline_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: results from plain arithmetic, latency from the per-bit cost rule.
    task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic edz, output int cyc);
        int n;
        int msb;
        if (b == 0) begin
            lo  = o ? 32'hFFFF_FFFF : 32'd0;
            hi  = o ? a : 32'd0;
            edz = o;
            cyc = 2;
        end else if (o) begin
            lo  = a / b;
            hi  = a % b;
            edz = 1'b0;
            cyc = 66;
        end else begin
            lo  = a * b;
            hi  = 32'd0;
            edz = 1'b0;
            msb = 0;
            for (int i = 0; i < 32; i++)
                if (b[i]) msb = i;
            n = 1;
            for (int i = 0; i <= msb; i++)
                n += 2 + int'(b[i]);
            cyc = n + 1;
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic edz,
                          input int ecyc, input bit noise, input string tag);
        int cyc;
        bit got;
        bit busy_ok;
        cline_log.delete();
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; got = 1'b0; busy_ok = 1'b1;
        while (cyc <= 200) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            cline_log.push_back(alu_cline);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (noise) begin
                start = 1'b1;
                op    = 1'($urandom_range(0, 1));
                opa   = $urandom;
                opb   = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
        check({tag, " done_cycle"}, cyc, ecyc);
        check({tag, " res_lo"}, res_lo, elo);
        check({tag, " res_hi"}, res_hi, ehi);
        check({tag, " dz"}, 32'(dz), 32'(edz));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " cline_in_done"}, 32'(alu_cline), 32'(CL_PASSB));
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_pulse_width"}, 32'(done), 32'd0);
        check({tag, " idle_after_done"}, 32'(busy), 32'd0);
        check({tag, " res_lo_held"}, res_lo, elo);
        $display("%s op=%0d a=%h b=%h -> lo=%h hi=%h dz=%0d done_cycle=%0d", tag, o, a, b,
                 res_lo, res_hi, dz, cyc);
    endtask

    initial begin
        logic [31:0] elo, ehi;
        logic        edz;
        int          ecyc;
        logic        ro;
        logic [31:0] ra, rb;
        logic [3:0]  exp_cl [$];

        vecs[0] = '{1'b0, 32'd6,          32'd7,          32'd42,         32'd0,          1'b0, 11};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd0,          1'b0, 7};
        vecs[2] = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          1'b0, 2};
        vecs[3] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 66};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 66};
        vecs[5] = '{1'b1, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 2};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 98};
        vecs[7] = '{1'b1, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 66};

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst res_lo", res_lo, 32'd0);
        check("rst res_hi", res_hi, 32'd0);
        check("rst dz", 32'(dz), 32'd0);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_cline", 32'(alu_cline), 32'(CL_PASSB));
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi,
                   vecs[i].dz, vecs[i].cyc, 1'b0, $sformatf("vec%0d", i));

        // ALU control sequence for 6*7
        run_op(1'b0, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 11, 1'b0, "mul_seq");
        exp_cl.push_back(CL_PASSB);
        for (int k = 0; k < 3; k++) begin
            exp_cl.push_back(CL_ADD);
            exp_cl.push_back(CL_SHL);
            exp_cl.push_back(CL_SHR);
        end
        check("mul_seq cline_count", cline_log.size(), exp_cl.size());
        for (int k = 0; k < exp_cl.size() && k < cline_log.size(); k++)
            check($sformatf("mul_seq cline[%0d]", k), 32'(cline_log[k]), 32'(exp_cl[k]));

        // Start pulses while busy and during DONE are ignored
        run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 66, 1'b1, "busy_start_div");
        run_op(1'b0, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 11, 1'b1, "busy_start_mul");

        // Reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("middiv busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("middiv_rst busy", 32'(busy), 32'd0);
        check("middiv_rst done", 32'(done), 32'd0);
        check("middiv_rst res_lo", res_lo, 32'd0);
        check("middiv_rst res_hi", res_hi, 32'd0);
        check("middiv_rst dz", 32'(dz), 32'd0);
        check("middiv_rst alu_cline", 32'(alu_cline), 32'(CL_PASSB));
        check("middiv_rst alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0, 8, 1'b0, "post_rst_mul");

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 255);
                2:       rb = 32'd0;
                3:       rb = 32'd1 << $urandom_range(0, 31);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            model(ro, ra, rb, elo, ehi, edz, ecyc);
            run_op(ro, ra, rb, elo, ehi, edz, ecyc, 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Multi-cycle unsigned multiply/divide sequencer. It is the initiator side of the execution-unit ALU interface.
- It drives the ALU's A, B and 4-bit control code, and consumes the ALU's 32-bit result and zero flag.
- Products and quotients are built iteratively through the existing combinational ALU, so the single-cycle datapath gains MUL/DIV without a second adder.
- Sits beside the ALU in the execute stage. The ALU input mux selects this block while busy is high.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (matches ALU).
- CL_ADD, 4'b0010, ALU code for A+B.
- CL_SUB, 4'b0011, ALU code for A-B.
- CL_SHL, 4'b0100, ALU code for A<<B.
- CL_SHR, 4'b0101, ALU code for A>>B (logical).
- CL_PASSB, 4'b0111, ALU code for res=B.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0=MUL (low 32 bits of product), 1=DIV (unsigned quotient/remainder).
- opa  in  32  multiplicand / dividend.
- opb  in  32  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start.
- res_lo  out  32  product low word / quotient.
- res_hi  out  32  0 for MUL / remainder for DIV.
- dz  out  1  divide-by-zero flag, valid with done, held with results.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_cline  out  4  ALU control code.
- alu_res  in  32  ALU result (combinational from alu_a/alu_b/alu_cline).
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, dz=0; res_lo, res_hi, all internal registers=0.
- Outputs during reset and in IDLE/DONE: alu_a=0, alu_b=0, alu_cline=CL_PASSB.
- ALU drive:
  - alu_* are decoded combinationally from registered state and registers. One ALU operation per cycle.
  - alu_res/alu_zero are captured at the clock edge ending that state.
- IDLE: on start=1, latch op, opa, opb into internal regs and go to CHK. busy rises next cycle.
- start while busy is ignored; no queueing.
- CHK: alu_a=0, alu_b=opb reg, alu_cline=CL_PASSB.
  - MUL and alu_zero=1: go to DONE with res_lo=0.
  - DIV and alu_zero=1: go to DONE with res_lo=32'hFFFFFFFF, res_hi=dividend, dz=1.
  - Otherwise: clear acc/rem/quo, set cnt=31, enter the first iteration.
- MUL loop (acc, mcand=opa, mplr=opb):
  - M_ADD: entered only if mplr[0]=1. CL_ADD(acc, mcand) -> acc.
  - M_SHL: CL_SHL(mcand, 1) -> mcand. Bits above 31 are discarded.
  - M_SHR: CL_SHR(mplr, 1) -> mplr.
    - If alu_zero=1: res_lo=acc, res_hi=0, go to DONE.
    - Else: go to M_ADD if the new mplr[0]=1, otherwise M_SHL.
  - Latency: 1 (CHK) + sum over bits 0..msb(opb) of (2 + bit). Maximum 97 ALU cycles.
- DIV loop, restoring (rem, quo, dvd=opa, dvs=opb), 32 iterations, exactly 2 states each:
  - D_SHL: CL_SHL(rem, 1).
    - carry = rem[31] before the shift; rem = alu_res | dvd[31]; dvd <<= 1 locally.
  - D_SUB: CL_SUB(rem, dvs).
    - If {carry,rem} >= {1'b0,dvs} (33-bit unsigned compare, local): rem=alu_res, quo={quo[30:0],1}.
    - Else: quo={quo[30:0],0}.
    - cnt==0: res_lo=quo (after this update), res_hi=rem, go to DONE. Else cnt-=1 and go to D_SHL.
  - Latency: 65 ALU cycles, fixed.
- DONE: done=1 for exactly this one cycle, busy=0, return to IDLE.
  - A start seen in DONE is ignored; start is accepted only in IDLE.
- Timing: done is high in the cycle immediately after the last ALU state. With start accepted at edge 0, done occurs in cycle N+1, where N = ALU-state count.
- Results and dz hold until the next accepted start, then clear at that start edge.

Test Plan:
- MUL 6*7 -> 10 ALU states (CHK, 3x{ADD,SHL,SHR}); done in cycle 11; res_lo=42, res_hi=0, dz=0; alu_cline sequence 0111,0010,0100,0101,...
- MUL 0xFFFFFFFF*2 -> states CHK,SHL,SHR,ADD,SHL,SHR; done in cycle 7; res_lo=0xFFFFFFFE.
- MUL 5*0 -> done in cycle 2, res_lo=0.
- DIV 100/7 -> done in cycle 66; res_lo=14, res_hi=2.
- DIV 0xFFFFFFFF/0x80000000 (exercises the carry compare) -> res_lo=1, res_hi=0x7FFFFFFF.
- DIV 1234/0 -> done in cycle 2; dz=1, res_lo=0xFFFFFFFF, res_hi=1234.
- Start pulses while busy -> ignored.
- rst asserted mid-DIV -> next cycle busy=0, done=0, results 0; a new MUL 3*3 afterwards returns 9.
